// File: rtl/quad_pkg.sv
// Shared quadrature encodings and Gray-sequence helpers for the encoder front end.
package quad_pkg;

    typedef logic [1:0] quad_state_t;

    localparam quad_state_t Q00 = 2'b00;
    localparam quad_state_t Q01 = 2'b01;
    localparam quad_state_t Q11 = 2'b11;
    localparam quad_state_t Q10 = 2'b10;

    // Next {A,B} state when the shaft turns forward.
    function automatic quad_state_t fwd_next(input quad_state_t s);
        quad_state_t n;
        n = Q00;
        unique case (s)
            Q00:     n = Q01;
            Q01:     n = Q11;
            Q11:     n = Q10;
            default: n = Q00;
        endcase
        return n;
    endfunction

    function automatic logic is_fwd(input quad_state_t prev, input quad_state_t cur);
        return cur == fwd_next(prev);
    endfunction

    // Both channels changing at once cannot be resolved into a direction.
    function automatic logic is_illegal(input quad_state_t prev, input quad_state_t cur);
        return (prev ^ cur) == 2'b11;
    endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Synchroniser plus saturating-count glitch filter for one asynchronous encoder pin.
// settled rises once the filtered level has been confirmed after reset.
module quad_input_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt,
    output logic settled
);

    localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES-1:0] sync_vld;
    logic [CW-1:0]          cnt;
    logic                   synced;
    logic                   sample_ok;

    assign synced    = sync[SYNC_STAGES-1];
    assign sample_ok = sync_vld[SYNC_STAGES-1];

    // sync_vld marks when the synchroniser holds real pin samples rather than reset zeros.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync     <= '0;
            sync_vld <= '0;
            cnt      <= '0;
            filt     <= 1'b0;
            settled  <= 1'b0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], raw};
            sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
            if (sample_ok) begin
                if (settled && (synced == filt)) begin
                    cnt <= '0;
                end else if (!settled && (synced != filt)) begin
                    filt <= synced;
                    cnt  <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt <= '0;
                    if (settled) begin
                        filt <= synced;
                    end else begin
                        settled <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/quadrature_decoder.sv
// x4 quadrature decoder: filtered A/B/Z in, step/direction pulses and modulo position out.
module quadrature_decoder
    import quad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned FILTER_LEN   = 4,
    parameter int unsigned MAX_NUM      = 1024,
    parameter int unsigned COUNTER_BITS = 31,
    parameter int unsigned INDEX_EN     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_in,
    input  logic                  a_in,
    input  logic                  b_in,
    input  logic                  z_in,
    input  logic                  clear_in,
    input  logic                  err_clr_in,
    output logic                  step_out,
    output logic                  dir_out,
    output logic [COUNTER_BITS:0] pos_out,
    output logic                  index_out,
    output logic                  err_out
);

    localparam int unsigned PW = COUNTER_BITS + 1;
    localparam logic [PW-1:0] POS_MAX = PW'(MAX_NUM - 1);

    logic a_filt, a_set, b_filt, b_set, z_filt, z_set;

    quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk(clk), .rst_n(rst_n), .raw(a_in), .filt(a_filt), .settled(a_set)
    );
    quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk(clk), .rst_n(rst_n), .raw(b_in), .filt(b_filt), .settled(b_set)
    );
    quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_z (
        .clk(clk), .rst_n(rst_n), .raw(z_in), .filt(z_filt), .settled(z_set)
    );

    logic          valid, valid_nxt;
    quad_state_t   prev_ab, prev_nxt, ab_cur;
    logic          z_prev;
    logic          z_rise_c;
    logic          step_nxt, dir_nxt, err_nxt;
    logic [PW-1:0] pos_nxt, pos_inc, pos_dec;

    assign ab_cur   = {a_filt, b_filt};
    assign z_rise_c = z_set & z_filt & ~z_prev;
    assign pos_inc  = (pos_out == POS_MAX) ? '0 : pos_out + PW'(1);
    assign pos_dec  = (pos_out == '0) ? POS_MAX : pos_out - PW'(1);

    // Decode and position priority: clear > index reload > step.
    always_comb begin
        valid_nxt = valid;
        prev_nxt  = prev_ab;
        step_nxt  = 1'b0;
        dir_nxt   = dir_out;
        pos_nxt   = pos_out;
        err_nxt   = err_out;

        if (err_clr_in) begin
            err_nxt = 1'b0;
        end

        if (!valid) begin
            if (a_set && b_set) begin
                valid_nxt = 1'b1;
                prev_nxt  = ab_cur;
            end
        end else if (ab_cur != prev_ab) begin
            prev_nxt = ab_cur;
            if (is_illegal(prev_ab, ab_cur)) begin
                err_nxt = 1'b1;
            end else if (en_in) begin
                step_nxt = 1'b1;
                dir_nxt  = is_fwd(prev_ab, ab_cur);
                pos_nxt  = is_fwd(prev_ab, ab_cur) ? pos_inc : pos_dec;
            end
        end

        if ((INDEX_EN != 0) && en_in && z_rise_c) begin
            pos_nxt = '0;
        end
        if (clear_in) begin
            pos_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid     <= 1'b0;
            prev_ab   <= Q00;
            z_prev    <= 1'b0;
            step_out  <= 1'b0;
            dir_out   <= 1'b1;
            pos_out   <= '0;
            index_out <= 1'b0;
            err_out   <= 1'b0;
        end else begin
            valid     <= valid_nxt;
            prev_ab   <= prev_nxt;
            z_prev    <= z_filt;
            step_out  <= step_nxt;
            dir_out   <= dir_nxt;
            pos_out   <= pos_nxt;
            index_out <= z_rise_c;
            err_out   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Scoreboard bench for quadrature_decoder: expected pulses are queued at drive time and matched on output.
module tb_quadrature_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en_in, a_in, b_in, z_in, clear_in, err_clr_in;
    logic        step0, dir0, index0, err0;
    logic        step1, dir1, index1, err1;
    logic [31:0] pos0, pos1;

    quadrature_decoder #(.INDEX_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .en_in(en_in), .a_in(a_in), .b_in(b_in), .z_in(z_in),
        .clear_in(clear_in), .err_clr_in(err_clr_in), .step_out(step0), .dir_out(dir0),
        .pos_out(pos0), .index_out(index0), .err_out(err0)
    );

    quadrature_decoder #(.INDEX_EN(0)) dut_noidx (
        .clk(clk), .rst_n(rst_n), .en_in(en_in), .a_in(a_in), .b_in(b_in), .z_in(z_in),
        .clear_in(clear_in), .err_clr_in(err_clr_in), .step_out(step1), .dir_out(dir1),
        .pos_out(pos1), .index_out(index1), .err_out(err1)
    );

    typedef struct {
        int   cyc;
        logic step;
        logic dir;
        int   pos;
        logic index;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   idx1_cnt = 0;

    logic [1:0] m_ab;
    logic       m_z, m_dir, m_err, m_en;
    int         m_pos, m_pos1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Match every step/index pulse of the INDEX_EN=1 instance against the queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (step0 === 1'b1 || index0 === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, step0, index0}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("latency", cyc, e.cyc);
                    check("step", {31'd0, step0}, {31'd0, e.step});
                    check("dir", {31'd0, dir0}, {31'd0, e.dir});
                    check("pos", pos0, e.pos);
                    check("index", {31'd0, index0}, {31'd0, e.index});
                end
            end else if (q.size() > 0 && cyc > q[0].cyc) begin
                check("missed_pulse", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (index1 === 1'b1) idx1_cnt++;
        end
    end

    function automatic logic [1:0] nf(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive new pin levels; when track is set, update the model and queue the expected pulse.
    task automatic drive(input logic [1:0] v, input logic z, input int hold, input bit track);
        logic st;
        logic ix;
        exp_t x;
        st = 1'b0;
        ix = 1'b0;
        if (track) begin
            if (v != m_ab) begin
                if ((v ^ m_ab) == 2'b11) begin
                    m_err = 1'b1;
                end else if (m_en) begin
                    st    = 1'b1;
                    m_dir = (v == nf(m_ab));
                    if (m_dir) begin
                        m_pos  = (m_pos + 1) % 1024;
                        m_pos1 = (m_pos1 + 1) % 1024;
                    end else begin
                        m_pos  = (m_pos + 1023) % 1024;
                        m_pos1 = (m_pos1 + 1023) % 1024;
                    end
                end
            end
            if (z && !m_z) begin
                ix = 1'b1;
                if (m_en) m_pos = 0;
            end
            if (st || ix) begin
                x.cyc   = cyc + 7;
                x.step  = st;
                x.dir   = m_dir;
                x.pos   = m_pos;
                x.index = ix;
                q.push_back(x);
            end
        end
        m_ab = v;
        m_z  = z;
        {a_in, b_in} = v;
        z_in = z;
        tick(hold);
    endtask

    task automatic pulse_clear();
        clear_in = 1'b1;
        tick(1);
        clear_in = 1'b0;
        m_pos  = 0;
        m_pos1 = 0;
    endtask

    task automatic pulse_err_clr();
        err_clr_in = 1'b1;
        tick(1);
        err_clr_in = 1'b0;
        m_err = 1'b0;
    endtask

    initial begin
        logic [1:0] fwd_seq[4];
        logic [1:0] rev_seq[4];
        fwd_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        rev_seq = '{2'b10, 2'b11, 2'b01, 2'b00};

        rst_n = 1'b0; en_in = 1'b1; a_in = 1'b0; b_in = 1'b0; z_in = 1'b0;
        clear_in = 1'b0; err_clr_in = 1'b0;
        m_ab = 2'b00; m_z = 1'b0; m_dir = 1'b1; m_err = 1'b0; m_en = 1'b1;
        m_pos = 0; m_pos1 = 0;
        tick(3);
        check("rst_pos", pos0, 32'd0);
        check("rst_dir", {31'd0, dir0}, 32'd1);
        check("rst_step", {31'd0, step0}, 32'd0);
        check("rst_index", {31'd0, index0}, 32'd0);
        check("rst_err", {31'd0, err0}, 32'd0);
        rst_n = 1'b1;
        tick(20);

        // Forward cycle
        foreach (fwd_seq[i]) drive(fwd_seq[i], 1'b0, 10, 1'b1);
        check("fwd_pos", pos0, m_pos);
        check("fwd_dir", {31'd0, dir0}, 32'd1);

        // Reverse from zero wraps to MAX_NUM-1
        pulse_clear();
        check("clear_pos", pos0, 32'd0);
        foreach (rev_seq[i]) drive(rev_seq[i], 1'b0, 10, 1'b1);
        check("rev_pos", pos0, 32'd1020);
        check("rev_dir", {31'd0, dir0}, 32'd0);

        // Short glitch on A is filtered out
        a_in = 1'b1;
        tick(3);
        a_in = 1'b0;
        tick(15);
        check("glitch_pos", pos0, m_pos);
        check("glitch_err", {31'd0, err0}, 32'd0);

        // Illegal double-bit change, clear, then set racing clear
        drive(2'b11, 1'b0, 10, 1'b1);
        check("illegal_err", {31'd0, err0}, {31'd0, m_err});
        check("illegal_pos", pos0, m_pos);
        pulse_err_clr();
        tick(1);
        check("err_clr", {31'd0, err0}, 32'd0);
        drive(2'b00, 1'b0, 6, 1'b1);
        err_clr_in = 1'b1;
        tick(1);
        err_clr_in = 1'b0;
        check("err_set_wins", {31'd0, err0}, 32'd1);
        tick(5);
        pulse_err_clr();
        tick(1);
        check("err_clr2", {31'd0, err0}, 32'd0);

        // Index coincident with a forward step at position 37
        pulse_clear();
        repeat (37) drive(nf(m_ab), 1'b0, 8, 1'b1);
        check("pos37", pos0, 32'd37);
        drive(nf(m_ab), 1'b1, 10, 1'b1);
        check("idx_pos", pos0, 32'd0);
        check("noidx_pos", pos1, 32'd38);
        check("noidx_index_cnt", idx1_cnt, 32'd1);
        drive(m_ab, 1'b0, 10, 1'b1);

        // Disabled decode tracks silently, re-enable is clean
        en_in = 1'b0;
        m_en  = 1'b0;
        repeat (3) drive(nf(m_ab), 1'b0, 10, 1'b1);
        tick(5);
        en_in = 1'b1;
        m_en  = 1'b1;
        tick(10);
        check("dis_pos", pos0, m_pos);
        check("dis_pos_noidx", pos1, m_pos1);
        drive(nf(m_ab), 1'b0, 10, 1'b1);
        check("reen_pos", pos0, m_pos);

        // Reset aborts an edge in flight
        drive(nf(m_ab), 1'b0, 3, 1'b0);
        rst_n = 1'b0;
        tick(2);
        check("midrst_pos", pos0, 32'd0);
        check("midrst_dir", {31'd0, dir0}, 32'd1);
        rst_n = 1'b1;
        m_pos = 0; m_pos1 = 0; m_dir = 1'b1; m_err = 1'b0;
        tick(20);
        check("postrst_pos", pos0, 32'd0);
        check("postrst_step", {31'd0, step0}, 32'd0);
        drive(nf(m_ab), 1'b0, 10, 1'b1);
        check("postrst_fwd", pos0, m_pos);
        check("postrst_fwd_noidx", pos1, m_pos1);

        tick(10);
        check("queue_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
